// File: rtl/fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and index-width helper.
package fifo_wr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after rr_ptr, scanning upward
// with wrap. Shared between the write and read sides of the FIFO.
module rr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx
);

    // First pass picks the lowest active index (the wrapped candidate); the second pass
    // overrides it with the lowest active index at or above the pointer, if there is one.
    always_comb begin
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) gnt_idx = IDX_W'(i);
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDX_W'(i) >= rr_ptr)) gnt_idx = IDX_W'(i);
        end
        gnt_oh = '0;
        if (|req) gnt_oh[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-locking round-robin arbiter for the async FIFO write port.
// Optional per-requester packet counters on pkt_cnt when FIFO_WR_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | no owner; pick next requester from rr_ptr, no data moves
// LOCK  | grant_id owns the write port until its req_last word is written
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  CNT_WIDTH  = 16,
    localparam int IDX_W      = idx_width(NUM_REQ)
) (
    input  logic                          wclk,
    input  logic                          wrst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          full,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_WIDTH-1:0]  pkt_cnt
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || CNT_WIDTH < 1) begin : g_param_chk
        $error("fifo_wr_arb: unsupported parameter value");
    end

    arb_state_t            state, state_nxt;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_REQ-1:0]    arb_oh;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_any;
    logic                  xfer;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    assign arb_any = |arb_oh;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign wdata = data_arr[grant_id];

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) state_nxt = LOCK;
            end
            LOCK: begin
                req_ready[grant_id] = !full;
                xfer                = req_valid[grant_id] && !full;
                if (xfer && req_last[grant_id]) state_nxt = IDLE;
            end
        endcase
    end

    assign eop  = xfer && req_last[grant_id];
    assign winc = xfer;
    assign busy = (state == LOCK);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_any) grant_id <= arb_idx;
            if (eop) begin
                rr_ptr <= (grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_WIDTH-1:0] cnt [NUM_REQ];

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
        end else if (eop) begin
            cnt[grant_id] <= cnt[grant_id] + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: per-source word scoreboard plus a cycle model of the arbiter.
module tb_fifo_wr_arb;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } word_t;

    logic         wclk;
    logic         wrst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_last;
    logic [3:0]   req_ready;
    logic         winc;
    logic [31:0]  wdata;
    logic         full;
    logic [1:0]   grant_id;
    logic         busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [63:0]  pkt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int seq      = 0;

    word_t       src_q [4][$];
    logic [31:0] exp_q [4][$];
    logic [3:0]  stall;
    int          grant_log [$];
    int          gcyc_log  [$];

    logic        m_state;
    logic [1:0]  m_ptr;
    logic [1:0]  m_gid;

    fifo_wr_arb #(
        .NUM_REQ    (4),
        .DATA_WIDTH (32),
        .CNT_WIDTH  (16)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .winc      (winc),
        .wdata     (wdata),
        .full      (full),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int len);
        word_t w;
        for (int k = 0; k < len; k++) begin
            w.d = {src[7:0], seq[23:0]};
            w.l = (k == len - 1);
            seq++;
            src_q[src].push_back(w);
            exp_q[src].push_back(w.d);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < 4; i++) n += src_q[i].size();
        return n;
    endfunction

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]          = !stall[i];
                req_data[i*32 +: 32]  = src_q[i][0].d;
                req_last[i]           = src_q[i][0].l;
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*32 +: 32]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic flush_and_reset_model();
        for (int i = 0; i < 4; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        m_state = 1'b0;
        m_ptr   = 2'd0;
        m_gid   = 2'd0;
    endtask

    // One clock: drive at posedge+1, check against the model at negedge, advance at posedge.
    task automatic cycle();
        logic [3:0] fire;
        logic [3:0] exp_ready;
        logic       exp_winc;
        logic       n_state;
        logic [1:0] n_ptr;
        logic [1:0] n_gid;
        int         idx;
        drive();
        @(negedge wclk);
        exp_ready = (m_state && !full) ? (4'b0001 << m_gid) : 4'b0000;
        exp_winc  = m_state && req_valid[m_gid] && !full;
        chk("winc", winc, exp_winc);
        chk("req_ready", req_ready, exp_ready);
        chk("busy", busy, m_state);
        chk("grant_id", grant_id, m_gid);
        if (exp_winc && exp_q[m_gid].size() > 0) chk("wdata", wdata, exp_q[m_gid].pop_front());
        fire    = req_valid & req_ready;
        n_state = m_state;
        n_ptr   = m_ptr;
        n_gid   = m_gid;
        if (!m_state) begin
            for (int k = 3; k >= 0; k--) begin
                idx = (int'(m_ptr) + k) % 4;
                if (req_valid[idx]) n_gid = 2'(idx);
            end
            if (|req_valid) n_state = 1'b1;
        end else if (exp_winc && req_last[m_gid]) begin
            n_state = 1'b0;
            n_ptr   = m_gid + 2'd1;
        end
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        if (!m_state && n_state) begin
            grant_log.push_back(int'(grant_id));
            gcyc_log.push_back(cyc);
        end
        m_state = n_state;
        m_ptr   = n_ptr;
        m_gid   = n_gid;
        cyc++;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((pending() > 0 || m_state) && n < budget) begin
            cycle();
            n++;
        end
        chk({"drain_", tag}, pending() + int'(m_state), 0);
    endtask

    initial begin
        int exp_fair [5] = '{0, 1, 2, 3, 0};
        int exp_wrap [3] = '{3, 0, 3};
        full      = 1'b0;
        stall     = '0;
        wrst_n    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        flush_and_reset_model();
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_winc", winc, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_grant", grant_id, 0);
        wrst_n = 1'b1;
        cycle();
        cycle();

        // asynchronous reset in the middle of a locked packet
        push_pkt(1, 3);
        cycle();
        cycle();
        chk("pre_rst_busy", busy, 1);
        wrst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_winc", winc, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_grant", grant_id, 0);
        flush_and_reset_model();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        push_pkt(2, 1);
        cycle();
        chk("rst_regrant", grant_id, 2);
        chk("rst_regrant_busy", busy, 1);
        drain("rst", 20);

        // bring rr_ptr back to 0, then fairness with 2-word packets from everyone
        push_pkt(3, 1);
        drain("align", 20);
        grant_log.delete();
        gcyc_log.delete();
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4; i++) push_pkt(i, 2);
        end
        drain("fair", 60);
        chk("fair_npkts", grant_log.size(), 8);
        for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
            chk($sformatf("fair_order%0d", k), grant_log[k], exp_fair[k]);
        end
        for (int k = 0; k < 4 && k + 1 < gcyc_log.size(); k++) begin
            chk($sformatf("fair_spacing%0d", k), gcyc_log[k+1] - gcyc_log[k], 3);
        end

        // pointer wrap: owner 3 finishes while 0 and 3 are both waiting
        push_pkt(2, 2);
        drain("wrap_setup", 20);
        grant_log.delete();
        push_pkt(3, 2);
        push_pkt(0, 2);
        push_pkt(3, 1);
        drain("wrap", 30);
        chk("wrap_npkts", grant_log.size(), 3);
        for (int k = 0; k < 3 && k < grant_log.size(); k++) begin
            chk($sformatf("wrap_order%0d", k), grant_log[k], exp_wrap[k]);
        end

        // full back-pressure mid-packet
        push_pkt(1, 6);
        cycle();
        cycle();
        cycle();
        full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("full_winc", winc, 0);
            chk("full_ready", req_ready, 0);
            chk("full_hold_grant", grant_id, 1);
        end
        full = 1'b0;
        drain("full", 20);

        // full while idle still arbitrates
        full = 1'b1;
        push_pkt(0, 2);
        cycle();
        chk("full_idle_busy", busy, 1);
        chk("full_idle_grant", grant_id, 0);
        cycle();
        chk("full_idle_winc", winc, 0);
        full = 1'b0;
        drain("full_idle", 20);

        // owner stalls mid-packet while another source waits
        grant_log.delete();
        push_pkt(1, 4);
        push_pkt(2, 2);
        cycle();
        cycle();
        cycle();
        stall[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("stall_grant", grant_id, 1);
            chk("stall_winc", winc, 0);
            chk("stall_busy", busy, 1);
        end
        stall[1] = 1'b0;
        drain("stall", 30);
        chk("stall_npkts", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            chk("stall_first", grant_log[0], 1);
            chk("stall_second", grant_log[1], 2);
        end

`ifdef FIFO_WR_ARB_STATS_EN
        wrst_n = 1'b0;
        #1;
        flush_and_reset_model();
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        chk("stats_reset", pkt_cnt, 64'd0);
        for (int p = 0; p < 3; p++) push_pkt(0, 2);
        push_pkt(2, 3);
        drain("stats", 60);
        chk("stats_cnt", pkt_cnt, {16'd0, 16'd1, 16'd0, 16'd3});
`endif

        chk("sb_leftover", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
